uart_rx_multi: RTL and testbench
================================

UART_RX_MULTI -- requirements
Module: uart_rx_multi

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, meaning clk cycles per serial bit (100 MHz / 9600 baud); legal range >= 8.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY_MODE, default 0, meaning 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked; legal 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of two, 2..16); used only with UART_RX_FIFO_EN.
REQ-006 SHALL have the following ports:
- clk  input  1  sole clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- uart_rx  input  1  asynchronous serial line; idles high.
- byte_rx  output  DATA_BITS  received data, LSB first on the line.
- valid_rx  output  1  byte_rx holds an unread byte.
- ready_rx  input  1  consumer accepts byte_rx when valid_rx and ready_rx are both high.
- done_rx  output  1  one-cycle pulse per good frame received.
- err_frame  output  1  one-cycle pulse; stop bit sampled low.
- err_parity  output  1  one-cycle pulse; parity mismatch.
- err_overrun  output  1  one-cycle pulse; good frame dropped because storage was full.

Function
REQ-007 SHALL pass uart_rx through a two-flop synchroniser before any use.
REQ-008 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-009 IDLE SHALL move to START on a synchronised high-to-low transition.
REQ-010 Bit value SHALL be the majority of three samples taken at bit-counter values CLKS_PER_BIT/2-1, CLKS_PER_BIT/2 and CLKS_PER_BIT/2+1.
REQ-011 START SHALL return to IDLE with no output pulse if its majority value is 1 (glitch rejection).
REQ-012 A valid START SHALL enter DATA; DATA SHALL shift DATA_BITS bits LSB-first; the bit counter SHALL reload at each bit boundary, one full CLKS_PER_BIT after the previous boundary.
REQ-013 PARITY SHALL be skipped when PARITY_MODE=0; otherwise even mode requires the XOR of data and parity bits to be 0, and odd mode requires it to be 1.
REQ-014 STOP SHALL check STOP_BITS stop bits; any stop bit with majority 0 SHALL pulse err_frame, discard the frame, and enter BREAK.
REQ-015 BREAK SHALL wait until the synchronised line is 1, then enter IDLE.
REQ-016 A parity mismatch SHALL pulse err_parity and discard the frame; err_parity and err_frame SHALL both pulse in the same cycle if both errors occur.
REQ-017 A good frame SHALL pulse done_rx and be written to storage in the clk cycle after the last stop-bit majority sample; the FSM SHALL then return to IDLE and be able to accept a start edge on the next cycle.
REQ-018 Storage write and consumer read in the same cycle when storage is full SHALL succeed with no overrun.
REQ-019 With storage full and no read, a good frame SHALL be dropped, with done_rx low and err_overrun pulsed; stored data SHALL be unchanged.
REQ-020 byte_rx SHALL be stable while valid_rx is high and ready_rx is low.

Reset
REQ-021 Asserting reset SHALL immediately force the following: FSM to IDLE; counters to 0; synchroniser flops to 1; byte_rx to 0; storage to empty; valid_rx, done_rx and all err_* outputs to 0.
REQ-022 Reset mid-frame SHALL discard the partial frame; after deassertion, the receiver SHALL wait for a fresh falling edge.

Configuration
REQ-023 With macro UART_RX_FIFO_EN defined, storage SHALL be a FIFO_DEPTH-entry FIFO; byte_rx SHALL show the head entry, and valid_rx SHALL mean not empty.
REQ-024 Without UART_RX_FIFO_EN, storage SHALL be a single holding register (depth 1), and FIFO_DEPTH SHALL be ignored.

Structure
REQ-025 Shared package uart_pkg SHALL hold the FSM state encoding and the PARITY_NONE/EVEN/ODD constants.
REQ-026 The FIFO SHALL be a sub-module uart_rx_fifo, instantiated only under UART_RX_FIFO_EN.

Verification
REQ-027 All scenarios SHALL use CLKS_PER_BIT=16 and sample outputs one cycle after the end of the stop bit.
REQ-028 Scenario 8N1 byte 0x3F: expect byte_rx=0x3F, one done_rx pulse, valid_rx=1 until ready_rx.
REQ-029 Scenario PARITY_MODE=1, byte 0xA5 with parity bit 1 (wrong): expect one err_parity pulse, no done_rx, valid_rx=0.
REQ-030 Scenario stop bit driven 0 for 3 bit times, then line returns high: expect err_frame, no done_rx, and no false start until the line returns high.
REQ-031 Scenario with a 4-cycle low glitch on an idle line: expect no pulses and FSM back in IDLE.
REQ-032 Scenario UART_RX_FIFO_EN with FIFO_DEPTH=4: send bytes 0x01..0x05 with ready_rx=0, then read all; expect reads 0x01..0x04 and one err_overrun on the fifth byte.
REQ-033 Scenario with reset pulsed low during data bit 4 of byte 0x55, then byte 0x3C sent: expect only 0x3C received.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM encoding, parity-mode constants and the 2-of-3 majority vote.
package uart_pkg;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} rx_state_t;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: DEPTH-entry receive FIFO; dout shows the head entry (zero when empty).
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = empty ? '0 : mem[rp[AW-1:0]];
    always_ff @(posedge clk)
        if (wr) mem[wp[AW-1:0]] <= din;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx_multi.sv
// uart_rx_multi: oversampling UART receiver with majority-vote bit decisions and optional parity.
// Defining UART_RX_FIFO_EN replaces the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_rx_multi
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] byte_rx,
    output logic                 valid_rx,
    input  logic                 ready_rx,
    output logic                 done_rx,
    output logic                 err_frame,
    output logic                 err_parity,
    output logic                 err_overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_S0   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_S1   = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_S2   = CW'(CLKS_PER_BIT / 2 + 1);
    rx_state_t state;
    logic s1, s2, prev;
    logic [CW-1:0] cnt;
    logic [3:0] idx;
    logic stop_idx;
    logic [1:0] smp;
    logic par, par_err;
    logic [DATA_BITS-1:0] sh;
    logic bit_v, mid, at_end, last_stop, good, rd, full, wr;
    assign bit_v     = maj3(smp[0], smp[1], s2);
    assign mid       = cnt == C_S2;
    assign at_end    = cnt == C_LAST;
    assign last_stop = stop_idx == 1'(STOP_BITS - 1);
    assign good      = state == S_STOP && mid && bit_v && last_stop && !par_err;
    assign rd        = valid_rx && ready_rx;
    assign wr        = good && (!full || rd);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1          <= 1'b1;
            s2          <= 1'b1;
            prev        <= 1'b1;
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            stop_idx    <= 1'b0;
            smp         <= '0;
            par         <= 1'b0;
            par_err     <= 1'b0;
            sh          <= '0;
            done_rx     <= 1'b0;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            s1          <= uart_rx;
            s2          <= s1;
            prev        <= s2;
            done_rx     <= wr;
            err_overrun <= good && !wr;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            cnt         <= (state == S_IDLE || state == S_BREAK || at_end) ? '0 : cnt + 1'b1;
            if (cnt == C_S0) smp[0] <= s2;
            if (cnt == C_S1) smp[1] <= s2;
            case (state)
                S_IDLE: if (prev && !s2) begin
                    state    <= S_START;
                    par      <= 1'b0;
                    par_err  <= 1'b0;
                    idx      <= '0;
                    stop_idx <= 1'b0;
                end
                S_START: if (mid && bit_v) state <= S_IDLE;
                         else if (at_end) state <= S_DATA;
                S_DATA: begin
                    if (mid) begin
                        sh  <= {bit_v, sh[DATA_BITS-1:1]};
                        par <= par ^ bit_v;
                    end
                    if (at_end) begin
                        idx <= idx + 1'b1;
                        if (idx == 4'(DATA_BITS - 1))
                            state <= (PARITY_MODE == PARITY_NONE) ? S_STOP : S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (mid) par_err <= (par ^ bit_v) != (PARITY_MODE == PARITY_ODD);
                    if (at_end) state <= S_STOP;
                end
                // both error pulses leave together at the stop-bit decision
                S_STOP: if (mid) begin
                    if (!bit_v) begin
                        err_frame  <= 1'b1;
                        err_parity <= par_err;
                        state      <= S_BREAK;
                    end else if (last_stop) begin
                        err_parity <= par_err;
                        state      <= S_IDLE;
                    end else stop_idx <= 1'b1;
                end
                S_BREAK: if (s2) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
`ifdef UART_RX_FIFO_EN
    logic empty;
    uart_rx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .wr(wr), .din(sh), .rd(rd),
        .dout(byte_rx), .full(full), .empty(empty)
    );
    assign valid_rx = !empty;
`else
    assign full = valid_rx;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_rx  <= '0;
            valid_rx <= 1'b0;
        end else if (wr) begin
            byte_rx  <= sh;
            valid_rx <= 1'b1;
        end else if (rd) valid_rx <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_uart_rx_multi.sv
// tb_uart_rx_multi: directed frames into an 8N1 receiver (a) and an 8E1 receiver (b).
module tb_uart_rx_multi;
    import uart_pkg::*;
    localparam int BIT = 16;
    logic clk = 1'b0;
    logic reset;
    logic rx_a, rx_b, ready_a, ready_b;
    logic [7:0] byte_a, byte_b;
    logic valid_a, valid_b, done_a, done_b;
    logic fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;
    int checks = 0, errors = 0;
    int n_done_a = 0, n_fe_a = 0, n_pe_a = 0, n_ov_a = 0;
    int n_done_b = 0, n_fe_b = 0, n_pe_b = 0, n_ov_b = 0;
    int d0, f0, p0, o0;
    always #5 clk = ~clk;
    uart_rx_multi #(.CLKS_PER_BIT(BIT), .PARITY_MODE(0), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .reset(reset), .uart_rx(rx_a), .byte_rx(byte_a), .valid_rx(valid_a),
        .ready_rx(ready_a), .done_rx(done_a), .err_frame(fe_a), .err_parity(pe_a), .err_overrun(ov_a)
    );
    uart_rx_multi #(.CLKS_PER_BIT(BIT), .PARITY_MODE(1)) u_b (
        .clk(clk), .reset(reset), .uart_rx(rx_b), .byte_rx(byte_b), .valid_rx(valid_b),
        .ready_rx(ready_b), .done_rx(done_b), .err_frame(fe_b), .err_parity(pe_b), .err_overrun(ov_b)
    );
    always @(posedge clk) begin
        if (done_a) n_done_a++;
        if (fe_a) n_fe_a++;
        if (pe_a) n_pe_a++;
        if (ov_a) n_ov_a++;
        if (done_b) n_done_b++;
        if (fe_b) n_fe_b++;
        if (pe_b) n_pe_b++;
        if (ov_b) n_ov_b++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic hold(input int sel, input logic v, input int n);
        if (sel == 0) rx_a = v; else rx_b = v;
        repeat (n) @(negedge clk);
    endtask
    // start, 8 data bits LSB first, optional parity, optional low stop time, then one high stop bit plus one cycle
    task automatic send(input int sel, input logic [7:0] d, input int par_en, input logic pb, input int stop_low);
        hold(sel, 1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(sel, d[i], BIT);
        if (par_en != 0) hold(sel, pb, BIT);
        if (stop_low > 0) hold(sel, 1'b0, stop_low);
        hold(sel, 1'b1, BIT + 1);
    endtask
    task automatic snap_a();
        d0 = n_done_a; f0 = n_fe_a; p0 = n_pe_a; o0 = n_ov_a;
    endtask
    task automatic snap_b();
        d0 = n_done_b; f0 = n_fe_b; p0 = n_pe_b; o0 = n_ov_b;
    endtask
    task automatic read_a();
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
    endtask
    initial begin
        reset = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid_a), 0);
        check("rst_byte", 32'(byte_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_state", 32'(u_a.state), 32'(S_IDLE));
        reset = 1'b1;
        repeat (5) @(negedge clk);
        snap_a();
        send(0, 8'h3F, 0, 1'b0, 0);
        check("8n1_byte", 32'(byte_a), 32'h3F);
        check("8n1_done", n_done_a - d0, 1);
        check("8n1_valid", 32'(valid_a), 1);
        check("8n1_errs", (n_fe_a - f0) + (n_pe_a - p0) + (n_ov_a - o0), 0);
        repeat (20) @(negedge clk);
        check("8n1_hold_byte", 32'(byte_a), 32'h3F);
        check("8n1_hold_valid", 32'(valid_a), 1);
        read_a();
        check("8n1_read", 32'(valid_a), 0);
        snap_b();
        send(1, 8'hA5, 1, 1'b1, 0);
        check("par_bad_pe", n_pe_b - p0, 1);
        check("par_bad_done", n_done_b - d0, 0);
        check("par_bad_valid", 32'(valid_b), 0);
        check("par_bad_fe", n_fe_b - f0, 0);
        snap_b();
        send(1, 8'hA5, 1, 1'b0, 0);
        check("par_ok_byte", 32'(byte_b), 32'hA5);
        check("par_ok_done", n_done_b - d0, 1);
        check("par_ok_pe", n_pe_b - p0, 0);
        snap_a();
        send(0, 8'h55, 0, 1'b0, 3 * BIT);
        check("frm_fe", n_fe_a - f0, 1);
        check("frm_done", n_done_a - d0, 0);
        check("frm_valid", 32'(valid_a), 0);
        check("frm_pe", n_pe_a - p0, 0);
        repeat (2 * BIT) @(negedge clk);
        check("frm_quiet", (n_fe_a - f0) + (n_done_a - d0), 1);
        check("frm_idle", 32'(u_a.state), 32'(S_IDLE));
        snap_a();
        send(0, 8'h81, 0, 1'b0, 0);
        check("frm_next_byte", 32'(byte_a), 32'h81);
        check("frm_next_done", n_done_a - d0, 1);
        read_a();
        snap_a();
        hold(0, 1'b0, 4);
        hold(0, 1'b1, 40);
        check("glitch_pulses", (n_done_a - d0) + (n_fe_a - f0) + (n_pe_a - p0) + (n_ov_a - o0), 0);
        check("glitch_idle", 32'(u_a.state), 32'(S_IDLE));
        check("glitch_valid", 32'(valid_a), 0);
        snap_a();
`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 0, 1'b0, 0);
        check("ovr_done", n_done_a - d0, 4);
        check("ovr_ov", n_ov_a - o0, 1);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_read", 32'(byte_a), 32'(i));
            read_a();
        end
        check("ovr_empty", 32'(valid_a), 0);
`else
        send(0, 8'h11, 0, 1'b0, 0);
        send(0, 8'h22, 0, 1'b0, 0);
        check("ovr_done", n_done_a - d0, 1);
        check("ovr_ov", n_ov_a - o0, 1);
        check("ovr_byte", 32'(byte_a), 32'h11);
        check("ovr_valid", 32'(valid_a), 1);
`endif
        hold(0, 1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(0, i[0] ? 1'b0 : 1'b1, BIT);
        hold(0, 1'b1, BIT / 2);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid_a), 0);
        check("mid_rst_byte", 32'(byte_a), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        hold(0, 1'b1, 2 * BIT);
        snap_a();
        send(0, 8'h3C, 0, 1'b0, 0);
        check("mid_rst_new_byte", 32'(byte_a), 32'h3C);
        check("mid_rst_done", n_done_a - d0, 1);
        check("mid_rst_errs", (n_fe_a - f0) + (n_pe_a - p0) + (n_ov_a - o0), 0);
        check("mid_rst_new_valid", 32'(valid_a), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
